// File: rtl/ex_muldiv.sv
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Iterative RV32M multiply/divide unit in EX; stalls IF..EX while busy.
//            Optional macro FAST_MUL_EN: single-cycle multiply in IDLE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [5:0]  stall,
   input  logic        flush_i,
   output logic        stallreq_o,
   output logic        busy_o,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic [4:0]  wd_o,
   output logic        wreg_o
);

   localparam logic [7:0] c_INST_MUL    = 8'h30;
   localparam logic [7:0] c_INST_MULH   = 8'h31;
   localparam logic [7:0] c_INST_MULHSU = 8'h32;
   localparam logic [7:0] c_INST_MULHU  = 8'h33;
   localparam logic [7:0] c_INST_DIV    = 8'h34;
   localparam logic [7:0] c_INST_DIVU   = 8'h35;
   localparam logic [7:0] c_INST_REM    = 8'h36;
   localparam logic [7:0] c_INST_REMU   = 8'h37;
   localparam logic       c_NOSTOP      = 1'b0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state, w_next;
   logic [31:0] r_a, r_b, r_quot, r_rem;
   logic [63:0] r_prod;
   logic [4:0]  r_cnt, r_wd;
   logic [7:0]  r_op;
   logic        r_sign1, r_sign2, r_wreg;

   logic        w_is_mul, w_is_div, w_s1, w_s2, w_neg1, w_neg2;
   logic        w_div0, w_ovf, w_mul_iter, w_fast_hit;
   logic [31:0] w_abs1, w_abs2, w_fast_res, w_q_fix, w_r_fix, w_done_res;
   logic [63:0] w_addend, w_p_fix;
   logic [32:0] w_shift, w_diff;
   logic        w_ge;
   logic        w_unused_stall;

   assign w_unused_stall = ^{stall[5:3], stall[1:0]};

   assign w_is_mul = aluop_i inside {c_INST_MUL, c_INST_MULH, c_INST_MULHSU, c_INST_MULHU};
   assign w_is_div = aluop_i inside {c_INST_DIV, c_INST_DIVU, c_INST_REM, c_INST_REMU};
   assign w_s1     = aluop_i inside {c_INST_MUL, c_INST_MULH, c_INST_MULHSU, c_INST_DIV, c_INST_REM};
   assign w_s2     = aluop_i inside {c_INST_MUL, c_INST_MULH, c_INST_DIV, c_INST_REM};
   assign w_neg1   = w_s1 & reg1_i[31];
   assign w_neg2   = w_s2 & reg2_i[31];
   assign w_abs1   = w_neg1 ? (~reg1_i + 32'd1) : reg1_i;
   assign w_abs2   = w_neg2 ? (~reg2_i + 32'd1) : reg2_i;
   assign w_div0   = (reg2_i == 32'd0);
   assign w_ovf    = w_s2 && (reg1_i == 32'h8000_0000) && (reg2_i == 32'hFFFF_FFFF);

`ifdef FAST_MUL_EN
   // Sign-extended 64-bit operands give the exact 33x33 signed product in the low 64 bits.
   logic [63:0] w_fa, w_fb, w_fp;
   assign w_fa       = {{32{w_neg1}}, reg1_i};
   assign w_fb       = {{32{w_neg2}}, reg2_i};
   assign w_fp       = w_fa * w_fb;
   assign w_fast_res = (aluop_i == c_INST_MUL) ? w_fp[31:0] : w_fp[63:32];
   assign w_fast_hit = w_is_mul;
   assign w_mul_iter = 1'b0;
`else
   assign w_fast_res = 32'd0;
   assign w_fast_hit = 1'b0;
   assign w_mul_iter = w_is_mul;
`endif

   assign w_addend = r_b[r_cnt] ? ({32'd0, r_a} << r_cnt) : 64'd0;
   assign w_shift  = {r_rem, r_quot[31]};
   assign w_ge     = (w_shift >= {1'b0, r_b});
   assign w_diff   = w_shift - {1'b0, r_b};

   assign w_p_fix  = (r_sign1 ^ r_sign2) ? (~r_prod + 64'd1) : r_prod;
   assign w_q_fix  = (r_sign1 ^ r_sign2) ? (~r_quot + 32'd1) : r_quot;
   assign w_r_fix  = r_sign1 ? (~r_rem + 32'd1) : r_rem;

   always_comb begin
      w_done_res = w_r_fix;
      case (r_op)
         c_INST_MUL:                              w_done_res = w_p_fix[31:0];
         c_INST_MULH, c_INST_MULHSU, c_INST_MULHU: w_done_res = w_p_fix[63:32];
         c_INST_DIV, c_INST_DIVU:                 w_done_res = w_q_fix;
         default:                                 w_done_res = w_r_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      stallreq_o = 1'b0;
      busy_o     = (r_state != S_IDLE);
      valid_o    = 1'b0;
      result_o   = 32'd0;
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mul_iter)    w_next = S_MUL;
            else if (w_is_div) w_next = (w_div0 || w_ovf) ? S_DONE : S_DIV;
            // Gate with reset so a held M op cannot raise outputs during reset.
            if (rst && !flush_i) begin
               stallreq_o = w_mul_iter | w_is_div;
               if (w_fast_hit) begin
                  valid_o  = 1'b1;
                  result_o = w_fast_res;
                  wd_o     = wd_i;
                  wreg_o   = wreg_i;
               end
            end
         end
         S_MUL, S_DIV: begin
            stallreq_o = 1'b1;
            if (r_cnt == 5'd31) w_next = S_DONE;
         end
         S_DONE: begin
            if (stall[2] == c_NOSTOP) w_next = S_IDLE;
            if (!flush_i) begin
               valid_o  = 1'b1;
               result_o = w_done_res;
               wd_o     = r_wd;
               wreg_o   = r_wreg;
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (flush_i) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a <= '0; r_b <= '0; r_quot <= '0; r_rem <= '0; r_prod <= '0;
         r_cnt <= '0; r_wd <= '0; r_op <= '0;
         r_sign1 <= 1'b0; r_sign2 <= 1'b0; r_wreg <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!flush_i && (w_mul_iter || w_is_div)) begin
                  r_a     <= w_abs1;
                  r_b     <= w_abs2;
                  r_quot  <= w_abs1;
                  r_rem   <= 32'd0;
                  r_prod  <= 64'd0;
                  r_cnt   <= 5'd0;
                  r_sign1 <= w_neg1;
                  r_sign2 <= w_neg2;
                  r_op    <= aluop_i;
                  r_wd    <= wd_i;
                  r_wreg  <= wreg_i;
                  // Special cases load final raw values; cleared signs bypass correction.
                  if (w_is_div && (w_div0 || w_ovf)) begin
                     r_quot  <= w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
                     r_rem   <= w_div0 ? reg1_i : 32'd0;
                     r_sign1 <= 1'b0;
                     r_sign2 <= 1'b0;
                  end
               end
            end
            S_MUL: begin
               r_prod <= r_prod + w_addend;
               r_cnt  <= r_cnt + 5'd1;
            end
            S_DIV: begin
               r_rem  <= w_ge ? w_diff[31:0] : w_shift[31:0];
               r_quot <= {r_quot[30:0], w_ge};
               r_cnt  <= r_cnt + 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
